// File: rtl/shift_left_iterative.sv
// Multi-cycle logical left shifter, one bit per clock, start/busy/done handshake.
// Optional signed-overflow flag on port ovf when SHL_OVF_EN is defined.
module shift_left_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done
`ifdef SHL_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] z_d;
  logic             accept;
  logic             enter_done;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_b;
  assign unused_b = ^b[WIDTH-1:5];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    z_d        = z;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept = 1'b1;
          acc_d  = a;
          cnt_d  = b[4:0];
          if (b[4:0] == 5'd0) begin
            state_d    = DONE;
            z_d        = a;
            enter_done = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = {acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d    = DONE;
          z_d        = acc_d;
          enter_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      z       <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

`ifdef SHL_OVF_EN
  logic ovf_r;
  logic step;

  // A step overflows when the bit about to become the sign differs from it.
  assign step = busy && (acc_q[WIDTH-1] != acc_q[WIDTH-2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept)
        ovf_r <= 1'b0;
      else if (step)
        ovf_r <= 1'b1;
      if (enter_done)
        ovf <= busy ? (ovf_r | step) : 1'b0;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = accept ^ enter_done;
`endif

endmodule

// File: tb/tb_shift_left_iterative.sv
// Randomized self-checking bench for shift_left_iterative.
// Reference model: a << n, latency n+1, signed-product overflow test.
module tb_shift_left_iterative;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  logic        busy;
  logic        done;
`ifdef SHL_OVF_EN
  logic        ovf;
`endif

  int n_chk;
  int n_fail;

  shift_left_iterative #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .z     (z),
    .busy  (busy),
    .done  (done)
`ifdef SHL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_z(input logic [31:0] av,
                                          input logic [31:0] bv);
    int n;
    longint unsigned p;
    n = int'(bv % 32);
    p = 64'(av) * (64'd1 << n);
    return p[31:0];
  endfunction

  function automatic logic model_ovf(input logic [31:0] av,
                                     input logic [31:0] bv);
    int n;
    longint sp;
    logic [31:0] r;
    n  = int'(bv % 32);
    sp = longint'($signed(av)) * (longint'(1) << n);
    r  = model_z(av, bv);
    return sp != longint'($signed(r));
  endfunction

  // Assumes we are at a negedge; launches an op and follows it to done.
  task automatic op_here(input logic [31:0] av, input logic [31:0] bv,
                         input bit inject, input string tag);
    int edges;
    int busy_cyc;
    int n;
    bit injected;
    n        = int'(bv % 32);
    injected = 0;
    start    = 1'b1;
    a        = av;
    b        = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      if (inject && busy && !injected) begin
        start    = 1'b1;
        a        = 32'h1;
        b        = 32'h1;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(edges), 32'(n + 1));
    check({tag, "_busy"}, 32'(busy_cyc), 32'(n));
    check({tag, "_z"}, z, model_z(av, bv));
`ifdef SHL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(model_ovf(av, bv)));
`endif
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input string tag);
    @(negedge clk);
    op_here(av, bv, 1'b0, tag);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    #3;
    check("rst_z", z, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
`ifdef SHL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h0000000F, 32'd4, "t_f4");
    check("t_f4_zval", z, 32'h000000F0);
    do_op(32'hFFFFFFFF, 32'd0, "t_n0");
    do_op(32'h00000001, 32'h1F, "t_n31");
    check("t_n31_zval", z, 32'h80000000);
    do_op(32'h00FFF000, 32'hFFFFFFE3, "t_hib");
    check("t_hib_zval", z, 32'h07FF8000);

    @(negedge clk);
    op_here(32'h3, 32'd2, 1'b1, "t_ign");
    check("t_ign_zval", z, 32'h0000000C);
    op_here(32'h12345678, 32'd5, 1'b0, "t_b2b");
    op_here(32'hDEADBEEF, 32'd0, 1'b0, "t_b2b0");
    op_here(32'h40000000, 32'd1, 1'b0, "t_b2b1");

    // Reset during the third SHIFT cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 32'hF0000000;
    b     = 32'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_z", z, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
`ifdef SHL_OVF_EN
    check("mid_rst_ovf", 32'(ovf), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h1, 32'h1, "t_post");
    check("t_post_zval", z, 32'h2);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb & 32'hFFFFFFE0;
      if (i % 3 == 0) op_here(ra, rb, 1'b0, "rnd_b2b");
      else do_op(ra, rb, "rnd");
    end

    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_done", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_left_iterative.md
# shift_left_iterative

- Multi-cycle 32-bit logical left shifter for the RISC datapath ALU; the left-shift counterpart of the single-cycle arithmetic right shifter.
- Shifts operand `a` left by `b[4:0]`, one bit position per clock, zero-filling from the LSB.
- Uses a start/busy/done handshake and holds the result on `z` until the next completion.
- Sits beside the combinational ALU units; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width; the shift amount field is always `b[4:0]`.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request; sampled only on edges where `busy`=0.
- `a`  in  WIDTH: value to shift; captured at the accepted start.
- `b`  in  WIDTH: shift amount; only `b[4:0]` is captured, `b[31:5]` is ignored.
- `z`  out  WIDTH: result register; updated only when the state enters DONE.
- `busy`  out  1: high while a shift is in progress.
- `done`  out  1: single-cycle pulse; `z` is valid in that cycle.
- `ovf`  out  1: signed-overflow flag, valid with `done`. Present only with `SHL_OVF_EN`.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: `acc` (WIDTH bits), `cnt` (5 bits), sticky `ovf_r`.
- IDLE or DONE, with `start`=1 at an edge:
  - Load `acc`=`a`, `cnt`=`b[4:0]`, clear `ovf_r`.
  - If `b[4:0]`==0: go to DONE, `z`=`a`.
  - Otherwise: go to SHIFT.
- IDLE or DONE, with `start`=0: go to (or stay in) IDLE.
- SHIFT, each edge:
  - `acc` = {`acc[WIDTH-2:0]`, 1'b0}; `cnt` -= 1.
  - If `acc[WIDTH-1]` != `acc[WIDTH-2]` before the shift, set `ovf_r`.
  - When `cnt` goes 1→0: go to DONE and load `z` with the shifted value.
- DONE lasts exactly one cycle, then goes to IDLE unless a new start is accepted in that cycle (back-to-back operation).
- `busy` = (state == SHIFT). `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- `start` while `busy`=1 is ignored; the captured `a` and `b` are unaffected by later input changes.
- Bits shifted out of the MSB are discarded. Shift amounts are modulo 32, consistent with the datapath shamt convention.

## Timing
- Reset (asynchronous, takes effect immediately): `z`=0, `busy`=0, `done`=0, `ovf`=0, state=IDLE, `acc`=0, `cnt`=0.
- Latency: for shift amount n, `done` is high in the cycle after the (n+1)-th rising edge, counting the start-accept edge as the first.
  - n=0: 1 edge.
  - n=31: 32 edges.
- `busy` is high for exactly n cycles (0 when n=0).
- Throughput: a new operation can be accepted in the DONE cycle, so back-to-back operations take n+1 cycles each.
- Reset asserted mid-shift aborts the operation. The first start after `rst_n` deasserts behaves normally.
- Deasserting `rst_n` takes effect at the next rising edge; `start` sampled at that edge is accepted.

## Configuration
- `SHL_OVF_EN` defined:
  - The `ovf` port and `ovf_r` logic are present.
  - `ovf` is loaded on entry to DONE: 1 if any single-bit step changed the sign bit, i.e. the result ≠ `a`·2^n as a signed value. Otherwise 0.
  - `ovf` holds until the next completion; reset value is 0.
- `SHL_OVF_EN` undefined: no `ovf` port and no overflow logic; all other behaviour is identical.

## Test plan
- `a`=0x0000000F, `b`=4, one-cycle start → `busy` high for 4 cycles, `done` after the 5th edge, `z`=0x000000F0.
- `a`=0xFFFFFFFF, `b`=0 → `busy` never rises, `done` after 1 edge, `z`=0xFFFFFFFF, `ovf`=0.
- `a`=0x00000001, `b`=0x1F → `done` after 32 edges, `z`=0x80000000; with `SHL_OVF_EN`, `ovf`=1.
- `a`=0x00FFF000, `b`=0xFFFFFFE3 (`b[4:0]`=3) → `z`=0x07FF8000, latency 4 edges.
- Second start with `a`=0x1 pulsed while `busy` during an `a`=0x3, `b`=2 operation → ignored, `z`=0x0000000C. A start in the DONE cycle is accepted back-to-back.
- `rst_n` low during the 3rd SHIFT cycle of `a`=0xF0000000, `b`=8 → `z`, `busy`, `done`, `ovf` go to 0 immediately. After release, `a`=0x1, `b`=1 gives `z`=0x2.
